cart_mem_arbiter: RTL and testbench

// Single owner of the cartridge SDRAM port. Sequences ROM-download byte writes

---
 rtl/cart_mem_pkg.sv | 20 ++
 rtl/cart_wr_fifo.sv | 64 ++++++
 rtl/cart_mem_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types for the cartridge SDRAM arbiter.
// Holds FSM states, write-buffer entry and open-bus value.
package cart_mem_pkg;

  localparam int MEM_AW = 25;

  localparam logic [7:0] CART_OPEN_BUS = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [7:0]        data;
  } wr_entry_t;

endpackage

// File: rtl/cart_wr_fifo.sv
// Download write buffer between the HPS loader and SDRAM.
// Synchronous FIFO; a push while full is taken only with a pop.
module cart_wr_fifo
  import cart_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      push_i,
  input  wr_entry_t din_i,
  input  logic      pop_i,
  output wr_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  wr_entry_t     mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    if (do_push & ~do_pop)
      cnt_d = cnt_q + (PW+1)'(1);
    else if (do_pop & ~do_push)
      cnt_d = cnt_q - (PW+1)'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Single owner of the cartridge SDRAM port.
// Serialises loader writes and console reads, with a one-entry cache.
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int CART_AW    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              dl_active_i,
  input  logic              dl_wr_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_data_i,
  output logic              dl_wait_o,
  output logic              dl_ovf_o,
  input  logic              cart_rd_i,
  input  logic [CART_AW-1:0] cart_a_i,
  output logic [7:0]        cart_d_o,
  output logic              cart_valid_o,
  output logic [5:0]        cart_pages_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_din_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_dout_i
);

  state_e state_q, state_d;

  logic              f_full;
  logic              f_empty;
  logic              f_push;
  logic              f_pop;
  wr_entry_t         f_din;
  wr_entry_t         f_head;

  logic [CART_AW-1:0] rd_addr_q, rd_addr_d;
  logic               rd_pend_q, rd_pend_d;
  logic [CART_AW-1:0] tag_q, tag_d;
  logic               cval_q, cval_d;
  logic [7:0]         cart_d_q, cart_d_d;
  logic               cvalid_q, cvalid_d;
  logic [5:0]         pages_q, pages_d;
  logic               ovf_q, ovf_d;
  logic               dl_act_q;
  logic [CART_AW-1:0] iss_q;

  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;

  logic acc_wr;
  logic drop_wr;
  logic dl_rise;
  logic ack_rd;
  logic hit;
  logic load_wr;
  logic load_rd;

  assign acc_wr  = dl_wr_i & ~f_full;
  assign drop_wr = dl_wr_i & f_full;
  assign dl_rise = dl_active_i & ~dl_act_q;
  assign ack_rd  = (state_q == RD) & mem_ack_i;
  assign hit     = cval_q & (cart_a_i == tag_q);

  assign f_push    = acc_wr;
  assign f_din     = '{addr: MEM_AW'(dl_addr_i),
                       data: dl_data_i};

  assign dl_wait_o    = f_full;
  assign dl_ovf_o     = ovf_q;
  assign cart_d_o     = cart_d_q;
  assign cart_valid_o = cvalid_q;
  assign cart_pages_o = pages_q;
  assign mem_req_o    = req_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_din_o    = din_q;

  cart_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (f_push),
    .din_i     (f_din),
    .pop_i     (f_pop),
    .dout_o    (f_head),
    .full_o    (f_full),
    .empty_o   (f_empty)
  );

  // Read tracking, cache, pages and overflow next-state
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_pend_d = rd_pend_q;
    tag_d     = tag_q;
    cval_d    = cval_q;
    cart_d_d  = cart_d_q;
    cvalid_d  = 1'b0;
    pages_d   = pages_q;
    ovf_d     = ovf_q;

    if (acc_wr) pages_d = dl_addr_i[19:14];
    if (dl_rise) ovf_d = 1'b0;
    if (drop_wr) ovf_d = 1'b1;

    if (ack_rd) begin
      cart_d_d = mem_dout_i;
      tag_d    = iss_q;
      cval_d   = 1'b1;
      cvalid_d = 1'b1;
    end

    if (cart_rd_i) begin
      if (dl_active_i) begin
        cart_d_d = CART_OPEN_BUS;
        cvalid_d = 1'b1;
      end else begin
        rd_addr_d = cart_a_i;
        if (hit) begin
          cvalid_d  = 1'b1;
          rd_pend_d = 1'b0;
        end else begin
          rd_pend_d = 1'b1;
        end
      end
    end

    // Completion retires the pending read unless retargeted
    if (ack_rd && (rd_addr_d == iss_q))
      rd_pend_d = 1'b0;

    if (dl_rise) begin
      cval_d    = 1'b0;
      rd_pend_d = 1'b0;
    end

    if (acc_wr && (dl_addr_i == ADDR_W'(tag_d)))
      cval_d = 1'b0;
  end

  // Request sequencing: writes win over reads
  always_comb begin
    state_d = state_q;
    f_pop   = 1'b0;
    load_wr = 1'b0;
    load_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          state_d = WR;
          load_wr = 1'b1;
        end else if (rd_pend_q && rd_pend_d &&
                     !dl_active_i) begin
          state_d = RD;
          load_rd = 1'b1;
        end
      end
      WR: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          f_pop   = 1'b1;
        end
      end
      RD: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Read, cache and status registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      tag_q     <= '0;
      cval_q    <= 1'b0;
      cart_d_q  <= CART_OPEN_BUS;
      cvalid_q  <= 1'b0;
      pages_q   <= '0;
      ovf_q     <= 1'b0;
      dl_act_q  <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
      tag_q     <= tag_d;
      cval_q    <= cval_d;
      cart_d_q  <= cart_d_d;
      cvalid_q  <= cvalid_d;
      pages_q   <= pages_d;
      ovf_q     <= ovf_d;
      dl_act_q  <= dl_active_i;
    end
  end

  // SDRAM request registers, frozen while req is up
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      iss_q  <= '0;
    end else if (load_wr) begin
      req_q  <= 1'b1;
      we_q   <= 1'b1;
      addr_q <= ADDR_W'(f_head.addr);
      din_q  <= f_head.data;
    end else if (load_rd) begin
      req_q  <= 1'b1;
      we_q   <= 1'b0;
      addr_q <= ADDR_W'(rd_addr_d);
      din_q  <= '0;
      iss_q  <= rd_addr_d;
    end else if (req_q && mem_ack_i) begin
      req_q  <= 1'b0;
      we_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed and randomized bench for cart_mem_arbiter.
// SDRAM responder plus a byte-level memory model predict read data.
module tb_cart_mem_arbiter;

  localparam int ADDR_W  = 25;
  localparam int CART_AW = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               dl_active = 1'b0;
  logic               dl_wr = 1'b0;
  logic [ADDR_W-1:0]  dl_addr = '0;
  logic [7:0]         dl_data = '0;
  logic               dl_wait;
  logic               dl_ovf;
  logic               cart_rd = 1'b0;
  logic [CART_AW-1:0] cart_a = '0;
  logic [7:0]         cart_d;
  logic               cart_valid;
  logic [5:0]         pages;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_din;
  logic               mem_ack = 1'b0;
  logic [7:0]         mem_dout = '0;

  always #5 clk = ~clk;

  cart_mem_arbiter dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .dl_active_i  (dl_active),
    .dl_wr_i      (dl_wr),
    .dl_addr_i    (dl_addr),
    .dl_data_i    (dl_data),
    .dl_wait_o    (dl_wait),
    .dl_ovf_o     (dl_ovf),
    .cart_rd_i    (cart_rd),
    .cart_a_i     (cart_a),
    .cart_d_o     (cart_d),
    .cart_valid_o (cart_valid),
    .cart_pages_o (pages),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_din_o    (mem_din),
    .mem_ack_i    (mem_ack),
    .mem_dout_i   (mem_dout)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sdram [int];
  logic [7:0] model [int];
  int         wr_a [$];
  logic [7:0] wr_d [$];
  int         rd_count = 0;
  int         last_rd = -1;
  int         valid_cnt = 0;
  int         fixed_lat = 1;
  bit         hold_ack = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input int a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sd_rd(input int a);
    if (sdram.exists(a)) return sdram[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] exp_rd(input int a);
    if (model.exists(a)) return model[a];
    return dflt(a);
  endfunction

  // SDRAM responder: ack after a latency, one cycle wide
  initial begin
    int cnt;
    int lat;
    bit acked;
    cnt = 0;
    lat = 1;
    acked = 1'b0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (acked) chk("req_drop", 32'(mem_req), 0);
      acked = 1'b0;
      if (!rst_n || !mem_req) begin
        cnt = 0;
      end else if (!hold_ack) begin
        if (cnt == 0)
          lat = (fixed_lat > 0) ? fixed_lat
                                : $urandom_range(1, 3);
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ack = 1'b1;
          acked = 1'b1;
          if (mem_we) begin
            sdram[int'(mem_addr)] = mem_din;
            wr_a.push_back(int'(mem_addr));
            wr_d.push_back(mem_din);
          end else begin
            mem_dout = sd_rd(int'(mem_addr));
            rd_count++;
            last_rd = int'(mem_addr);
          end
        end
      end
    end
  end

  // Count completion pulses
  initial begin
    forever begin
      @(negedge clk);
      if (cart_valid === 1'b1) valid_cnt++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d);
    int g;
    g = 0;
    while (dl_wait && g < 200) begin
      tick(1);
      g++;
    end
    chk("dl_stall_bound", 32'(dl_wait), 0);
    dl_wr = 1'b1;
    dl_addr = ADDR_W'(a);
    dl_data = d;
    model[a] = d;
    tick(1);
    dl_wr = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int g;
    g = 0;
    while (wr_a.size() < n && g < 400) begin
      tick(1);
      g++;
    end
    chk(tag, wr_a.size(), n);
  endtask

  task automatic wait_valid(input int base, input string tag);
    int g;
    g = 0;
    while (valid_cnt <= base && g < 100) begin
      tick(1);
      g++;
    end
    chk(tag, 32'(valid_cnt > base), 1);
  endtask

  task automatic rd_strobe(input int a);
    cart_rd = 1'b1;
    cart_a = CART_AW'(a);
    tick(1);
    cart_rd = 1'b0;
  endtask

  initial begin
    int vb;
    int rb;
    int n;
    int a;
    int total;
    logic [7:0] d;

    // Reset and idle state
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_cart_d", 32'(cart_d), 32'h00FF);
    chk("rst_wait", 32'(dl_wait), 0);
    chk("rst_pages", 32'(pages), 0);
    chk("rst_valid", 32'(cart_valid), 0);
    chk("rst_ovf", 32'(dl_ovf), 0);

    // Three-byte download, ack latency 2
    fixed_lat = 2;
    dl_active = 1'b1;
    tick(1);
    dl_byte(32'h4000, 8'h11);
    dl_byte(32'h4001, 8'h22);
    dl_byte(32'h4002, 8'h33);
    wait_writes(3, "dl3_count");
    for (int i = 0; i < 3; i++) begin
      chk("dl3_addr", wr_a[i], 32'h4000 + i);
      chk("dl3_data", 32'(wr_d[i]), 32'h11 * (i + 1));
    end
    chk("dl3_pages", 32'(pages), 1);
    chk("dl3_no_reads", rd_count, 0);
    tick(4);
    chk("dl3_idle_req", 32'(mem_req), 0);
    chk("dl3_wait", 32'(dl_wait), 0);
    dl_active = 1'b0;
    tick(2);

    // Six strobes with ack withheld
    dl_active = 1'b1;
    hold_ack = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) chk("ovf_not_full", 32'(dl_wait), 0);
      if (i == 4) chk("ovf_full", 32'(dl_wait), 1);
      dl_wr = 1'b1;
      dl_addr = ADDR_W'(32'h8000 + i * 32'h4000);
      dl_data = 8'(8'h40 + i);
      tick(1);
    end
    dl_wr = 1'b0;
    chk("ovf_flag", 32'(dl_ovf), 1);
    chk("ovf_wait_held", 32'(dl_wait), 1);
    chk("ovf_pages", 32'(pages), 5);
    hold_ack = 1'b0;
    wait_writes(7, "ovf_count");
    tick(20);
    chk("ovf_exact", wr_a.size(), 7);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_addr", wr_a[3 + i], 32'h8000 + i * 32'h4000);
      chk("ovf_data", 32'(wr_d[3 + i]), 32'h40 + i);
    end
    chk("ovf_wait_clear", 32'(dl_wait), 0);
    chk("ovf_sticky", 32'(dl_ovf), 1);
    dl_active = 1'b0;
    tick(2);

    // Miss then hit on 0x00123
    fixed_lat = 3;
    sdram[32'h123] = 8'hA5;
    vb = valid_cnt;
    rb = rd_count;
    rd_strobe(32'h123);
    wait_valid(vb, "miss_valid");
    chk("miss_data", 32'(cart_d), 32'hA5);
    tick(10);
    chk("miss_pulses", valid_cnt, vb + 1);
    chk("miss_reads", rd_count, rb + 1);
    chk("miss_addr", last_rd, 32'h123);
    vb = valid_cnt;
    rb = rd_count;
    rd_strobe(32'h123);
    wait_valid(vb, "hit_valid");
    tick(10);
    chk("hit_pulses", valid_cnt, vb + 1);
    chk("hit_no_read", rd_count, rb);
    chk("hit_data", 32'(cart_d), 32'hA5);

    // Read during download returns open bus
    rb = rd_count;
    dl_active = 1'b1;
    rd_strobe(32'h123);
    chk("dlrd_valid", 32'(cart_valid), 1);
    chk("dlrd_data", 32'(cart_d), 32'hFF);
    chk("dlrd_ovf_clr", 32'(dl_ovf), 0);
    tick(10);
    chk("dlrd_no_read", rd_count, rb);
    dl_active = 1'b0;
    tick(10);
    chk("dlrd_after", rd_count, rb);

    // Retargeted read: latest address wins
    sdram[32'h10] = 8'h3C;
    sdram[32'h20] = 8'hC3;
    vb = valid_cnt;
    rb = rd_count;
    cart_rd = 1'b1;
    cart_a = CART_AW'(32'h10);
    tick(1);
    cart_a = CART_AW'(32'h20);
    tick(1);
    cart_rd = 1'b0;
    wait_valid(vb, "retgt_valid");
    tick(10);
    chk("retgt_data", 32'(cart_d), 32'hC3);
    chk("retgt_pulses", valid_cnt, vb + 1);
    chk("retgt_reads", rd_count, rb + 1);
    chk("retgt_addr", last_rd, 32'h20);

    // Random downloads and reads against the model
    fixed_lat = 0;
    total = wr_a.size();
    for (int it = 0; it < 12; it++) begin
      dl_active = 1'b1;
      tick(1);
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        a = $urandom_range(0, 15);
        d = 8'($urandom);
        dl_byte(a, d);
      end
      total += n;
      dl_active = 1'b0;
      wait_writes(total, "rnd_wr_count");
      tick(2);
      for (int r = 0; r < 3; r++) begin
        a = $urandom_range(0, 15);
        vb = valid_cnt;
        rd_strobe(a);
        wait_valid(vb, "rnd_valid");
        tick(1);
        chk("rnd_data", 32'(cart_d), 32'(exp_rd(a)));
        tick(2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
